// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared opcodes, state encodings, IR field positions and strobe indices
package control_unit_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        CLS_BINARY,
        CLS_UNARY,
        CLS_MULDIV
    } op_class_t;

    localparam logic [4:0] OP_ADD    = 5'b00011;
    localparam logic [4:0] OP_SUB    = 5'b00100;
    localparam logic [4:0] OP_SHR    = 5'b00101;
    localparam logic [4:0] OP_SHL    = 5'b00110;
    localparam logic [4:0] OP_ROR    = 5'b00111;
    localparam logic [4:0] OP_ROL    = 5'b01000;
    localparam logic [4:0] OP_AND    = 5'b01001;
    localparam logic [4:0] OP_OR     = 5'b01010;
    localparam logic [4:0] OP_MUL    = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_NEGATE = 5'b10000;
    localparam logic [4:0] OP_NOT    = 5'b10001;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // ALU strobe vector bit positions
    localparam int ALU_W    = 12;
    localparam int A_ADD    = 0;
    localparam int A_SUB    = 1;
    localparam int A_MUL    = 2;
    localparam int A_DIV    = 3;
    localparam int A_SHR    = 4;
    localparam int A_SHL    = 5;
    localparam int A_ROR    = 6;
    localparam int A_ROL    = 7;
    localparam int A_AND    = 8;
    localparam int A_OR     = 9;
    localparam int A_NEGATE = 10;
    localparam int A_NOT    = 11;

    // Single-bit load/drive strobe vector bit positions
    localparam int CTL_W     = 15;
    localparam int C_PCIN    = 0;
    localparam int C_IRIN    = 1;
    localparam int C_RYIN    = 2;
    localparam int C_RZIN    = 3;
    localparam int C_MARIN   = 4;
    localparam int C_HIIN    = 5;
    localparam int C_LOIN    = 6;
    localparam int C_MDRIN   = 7;
    localparam int C_READ    = 8;
    localparam int C_PCOUT   = 9;
    localparam int C_MDROUT  = 10;
    localparam int C_ZLOWOUT = 11;
    localparam int C_ZHIOUT  = 12;
    localparam int C_INCPC   = 13;
    localparam int C_ILLEGAL = 14;

endpackage

// File: rtl/control_unit_op_decode.sv
// rtl/control_unit_op_decode.sv - opcode to ALU strobe, instruction class and illegal flag
module op_decode
    import control_unit_pkg::*;
(
    input  logic [4:0]       op,
    output logic [ALU_W-1:0] alu_strobe,
    output op_class_t        op_class,
    output logic             illegal
);

    always_comb begin
        alu_strobe = '0;
        op_class   = CLS_BINARY;
        illegal    = 1'b0;
        case (op)
            OP_ADD:    alu_strobe[A_ADD] = 1'b1;
            OP_SUB:    alu_strobe[A_SUB] = 1'b1;
            OP_SHR:    alu_strobe[A_SHR] = 1'b1;
            OP_SHL:    alu_strobe[A_SHL] = 1'b1;
            OP_ROR:    alu_strobe[A_ROR] = 1'b1;
            OP_ROL:    alu_strobe[A_ROL] = 1'b1;
            OP_AND:    alu_strobe[A_AND] = 1'b1;
            OP_OR:     alu_strobe[A_OR]  = 1'b1;
            OP_MUL: begin
                alu_strobe[A_MUL] = 1'b1;
                op_class          = CLS_MULDIV;
            end
            OP_DIV: begin
                alu_strobe[A_DIV] = 1'b1;
                op_class          = CLS_MULDIV;
            end
            OP_NEGATE: begin
                alu_strobe[A_NEGATE] = 1'b1;
                op_class             = CLS_UNARY;
            end
            OP_NOT: begin
                alu_strobe[A_NOT] = 1'b1;
                op_class          = CLS_UNARY;
            end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/execute sequencer driving the datapath strobes
module control_unit
    import control_unit_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic [BITS-1:0]      IR,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 PCin,
    output logic                 IRin,
    output logic                 RYin,
    output logic                 RZin,
    output logic                 MARin,
    output logic                 HIin,
    output logic                 LOin,
    output logic                 MDRin,
    output logic                 Read,
    output logic                 PCout,
    output logic                 MDRout,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 LOout,
    output logic                 HIout,
    output logic                 IncPC,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 MUL,
    output logic                 DIV,
    output logic                 SHR,
    output logic                 SHL,
    output logic                 ROR,
    output logic                 ROL,
    output logic                 AND,
    output logic                 OR,
    output logic                 NEGATE,
    output logic                 NOT,
    output logic                 Illegal,
    output logic [31:0]          InstrCount
);

    state_t           state, nxt;
    logic [3:0]       ra_q, rb_q, rc_q, n_ra, n_rb, n_rc;
    logic [ALU_W-1:0] op_alu_q, n_op_alu;
    op_class_t        cls_q, n_cls;

    logic [ALU_W-1:0] dec_alu;
    op_class_t        dec_cls;
    logic             dec_illegal;

    logic [CTL_W-1:0]     ctl_q, nx_ctl;
    logic [ALU_W-1:0]     alu_q, nx_alu;
    logic [REGISTERS-1:0] gin_q, gout_q, nx_gin, nx_gout;
    logic [31:0]          count_q;
    logic                 retire;

    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[RC_LSB-1:0];

    function automatic logic [REGISTERS-1:0] reg_sel(input logic [3:0] r);
        return {{(REGISTERS-1){1'b0}}, 1'b1} << (int'(r) % REGISTERS);
    endfunction

    op_decode u_op_decode (
        .op         (IR[OP_MSB:OP_LSB]),
        .alu_strobe (dec_alu),
        .op_class   (dec_cls),
        .illegal    (dec_illegal)
    );

    // Fields come straight from IR on the T2->T3 edge so T3 outputs can use them
    always_comb begin
        n_ra     = ra_q;
        n_rb     = rb_q;
        n_rc     = rc_q;
        n_op_alu = op_alu_q;
        n_cls    = cls_q;
        if (state == S_T2) begin
            n_ra     = IR[RA_MSB:RA_LSB];
            n_rb     = IR[RB_MSB:RB_LSB];
            n_rc     = IR[RC_MSB:RC_LSB];
            n_op_alu = dec_alu;
            n_cls    = dec_cls;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            S_RST:   nxt = S_T0;
            S_T0:    nxt = S_T1;
            S_T1:    nxt = S_T2;
            S_T2:    nxt = dec_illegal ? S_HALT : S_T3;
            S_T3:    nxt = S_T4;
            S_T4:    nxt = S_T5;
            S_T5:    nxt = (cls_q == CLS_MULDIV) ? S_T6 : S_T0;
            S_T6:    nxt = S_T0;
            S_HALT:  nxt = S_HALT;
            default: nxt = S_RST;
        endcase
    end

    assign retire = (state == S_T5 && cls_q != CLS_MULDIV) || (state == S_T6);

    // Outputs for the state being entered, registered so they are glitch-free Moore strobes
    always_comb begin
        nx_ctl  = '0;
        nx_alu  = '0;
        nx_gin  = '0;
        nx_gout = '0;
        case (nxt)
            S_T0: begin
                nx_ctl[C_PCOUT] = 1'b1;
                nx_ctl[C_MARIN] = 1'b1;
                nx_ctl[C_INCPC] = 1'b1;
                nx_ctl[C_RZIN]  = 1'b1;
            end
            S_T1: begin
                nx_ctl[C_ZLOWOUT] = 1'b1;
                nx_ctl[C_PCIN]    = 1'b1;
                nx_ctl[C_READ]    = 1'b1;
                nx_ctl[C_MDRIN]   = 1'b1;
            end
            S_T2: begin
                nx_ctl[C_MDROUT] = 1'b1;
                nx_ctl[C_IRIN]   = 1'b1;
            end
            S_T3: begin
                nx_gout        = reg_sel(n_rb);
                nx_ctl[C_RYIN] = 1'b1;
            end
            S_T4: begin
                nx_gout        = reg_sel((n_cls == CLS_UNARY) ? n_rb : n_rc);
                nx_alu         = n_op_alu;
                nx_ctl[C_RZIN] = 1'b1;
            end
            S_T5: begin
                nx_ctl[C_ZLOWOUT] = 1'b1;
                if (n_cls == CLS_MULDIV)
                    nx_ctl[C_LOIN] = 1'b1;
                else
                    nx_gin = reg_sel(n_ra);
            end
            S_T6: begin
                nx_ctl[C_ZHIOUT] = 1'b1;
                nx_ctl[C_HIIN]   = 1'b1;
            end
            S_HALT:  nx_ctl[C_ILLEGAL] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state    <= S_RST;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            op_alu_q <= '0;
            cls_q    <= CLS_BINARY;
            ctl_q    <= '0;
            alu_q    <= '0;
            gin_q    <= '0;
            gout_q   <= '0;
            count_q  <= '0;
        end else begin
            state    <= nxt;
            ra_q     <= n_ra;
            rb_q     <= n_rb;
            rc_q     <= n_rc;
            op_alu_q <= n_op_alu;
            cls_q    <= n_cls;
            ctl_q    <= nx_ctl;
            alu_q    <= nx_alu;
            gin_q    <= nx_gin;
            gout_q   <= nx_gout;
            if (retire)
                count_q <= count_q + 32'd1;
        end
    end

    assign GPRin      = gin_q;
    assign GPRout     = gout_q;
    assign PCin       = ctl_q[C_PCIN];
    assign IRin       = ctl_q[C_IRIN];
    assign RYin       = ctl_q[C_RYIN];
    assign RZin       = ctl_q[C_RZIN];
    assign MARin      = ctl_q[C_MARIN];
    assign HIin       = ctl_q[C_HIIN];
    assign LOin       = ctl_q[C_LOIN];
    assign MDRin      = ctl_q[C_MDRIN];
    assign Read       = ctl_q[C_READ];
    assign PCout      = ctl_q[C_PCOUT];
    assign MDRout     = ctl_q[C_MDROUT];
    assign Zlowout    = ctl_q[C_ZLOWOUT];
    assign Zhighout   = ctl_q[C_ZHIOUT];
    assign IncPC      = ctl_q[C_INCPC];
    assign Illegal    = ctl_q[C_ILLEGAL];
    assign LOout      = 1'b0;
    assign HIout      = 1'b0;
    assign ADD        = alu_q[A_ADD];
    assign SUB        = alu_q[A_SUB];
    assign MUL        = alu_q[A_MUL];
    assign DIV        = alu_q[A_DIV];
    assign SHR        = alu_q[A_SHR];
    assign SHL        = alu_q[A_SHL];
    assign ROR        = alu_q[A_ROR];
    assign ROL        = alu_q[A_ROL];
    assign AND        = alu_q[A_AND];
    assign OR         = alu_q[A_OR];
    assign NEGATE     = alu_q[A_NEGATE];
    assign NOT        = alu_q[A_NOT];
    assign InstrCount = count_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed-vector bench for control_unit
module tb_control_unit;

    logic        Clock;
    logic        reset;
    logic [31:0] IR;
    logic [15:0] GPRin, GPRout;
    logic PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read;
    logic PCout, MDRout, Zlowout, Zhighout, LOout, HIout;
    logic IncPC, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;
    logic Illegal;
    logic [31:0] InstrCount;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [15:0] B_PCIN  = 16'h8000, B_IRIN  = 16'h4000, B_RYIN  = 16'h2000;
    localparam logic [15:0] B_RZIN  = 16'h1000, B_MARIN = 16'h0800, B_HIIN  = 16'h0400;
    localparam logic [15:0] B_LOIN  = 16'h0200, B_MDRIN = 16'h0100, B_READ  = 16'h0080;
    localparam logic [15:0] B_PCOUT = 16'h0040, B_MDROUT = 16'h0020, B_ZLO  = 16'h0010;
    localparam logic [15:0] B_ZHI   = 16'h0008, B_INCPC = 16'h0001;

    localparam logic [11:0] X_ADD = 12'h800, X_MUL = 12'h200, X_DIV = 12'h100;
    localparam logic [11:0] X_AND = 12'h008, X_NOT = 12'h001;

    localparam logic [31:0] IR_AND = 32'h4A920000;  // AND R5,R2,R4
    localparam logic [31:0] IR_ADD = 32'h18918000;  // ADD R1,R2,R3
    localparam logic [31:0] IR_MUL = 32'h701A0000;  // MUL R3,R4
    localparam logic [31:0] IR_BAD = 32'hF8000000;
    localparam logic [31:0] IR_NOT = 32'h8B380000;  // NOT R6,R7
    localparam logic [31:0] IR_DIV = 32'h78448000;  // DIV R8,R9

    wire [15:0] obs_ctl = {PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read,
                           PCout, MDRout, Zlowout, Zhighout, LOout, HIout, IncPC};
    wire [11:0] obs_alu = {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT};

    control_unit #(.BITS(32), .REGISTERS(16)) dut (
        .Clock(Clock), .reset(reset), .IR(IR),
        .GPRin(GPRin), .GPRout(GPRout),
        .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
        .HIin(HIin), .LOin(LOin), .MDRin(MDRin), .Read(Read),
        .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .LOout(LOout), .HIout(HIout), .IncPC(IncPC),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
        .Illegal(Illegal), .InstrCount(InstrCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic [15:0] c, input logic [11:0] a,
                                input logic [15:0] gi, input logic [15:0] go);
        @(negedge Clock);
        check_eq({tag, "/ctl"}, 64'(obs_ctl), 64'(c));
        check_eq({tag, "/alu"}, 64'(obs_alu), 64'(a));
        check_eq({tag, "/gprin"}, 64'(GPRin), 64'(gi));
        check_eq({tag, "/gprout"}, 64'(GPRout), 64'(go));
    endtask

    task automatic fetch(input string tag);
        expect_cycle({tag, "/T0"}, B_PCOUT | B_MARIN | B_INCPC | B_RZIN, 12'h0, 16'h0, 16'h0);
        expect_cycle({tag, "/T1"}, B_ZLO | B_PCIN | B_READ | B_MDRIN, 12'h0, 16'h0, 16'h0);
        expect_cycle({tag, "/T2"}, B_MDROUT | B_IRIN, 12'h0, 16'h0, 16'h0);
    endtask

    task automatic expect_zero(input string tag);
        check_eq({tag, "/ctl"}, 64'(obs_ctl), 64'h0);
        check_eq({tag, "/alu"}, 64'(obs_alu), 64'h0);
        check_eq({tag, "/gprin"}, 64'(GPRin), 64'h0);
        check_eq({tag, "/gprout"}, 64'(GPRout), 64'h0);
        check_eq({tag, "/illegal"}, 64'(Illegal), 64'h0);
    endtask

    // Structural invariants sampled every cycle
    always @(negedge Clock) begin
        check_eq("one_bus_driver",
                 64'($countones({PCout, MDRout, Zlowout, Zhighout, LOout, HIout, GPRout}) <= 1), 64'h1);
        check_eq("one_alu_strobe", 64'($countones(obs_alu) <= 1), 64'h1);
        check_eq("one_gprin", 64'($countones(GPRin) <= 1), 64'h1);
    end

    initial begin
        reset = 1'b1;
        IR    = IR_AND;
        repeat (2) @(negedge Clock);
        expect_zero("reset");
        check_eq("reset/count", 64'(InstrCount), 64'd0);
        reset = 1'b0;

        fetch("and");
        expect_cycle("and/T3", B_RYIN, 12'h0, 16'h0, 16'h0004);
        expect_cycle("and/T4", B_RZIN, X_AND, 16'h0, 16'h0010);
        expect_cycle("and/T5", B_ZLO, 12'h0, 16'h0020, 16'h0);
        IR = IR_ADD;
        fetch("add");
        check_eq("and/count", 64'(InstrCount), 64'd1);
        expect_cycle("add/T3", B_RYIN, 12'h0, 16'h0, 16'h0004);
        expect_cycle("add/T4", B_RZIN, X_ADD, 16'h0, 16'h0008);
        expect_cycle("add/T5", B_ZLO, 12'h0, 16'h0002, 16'h0);
        IR = IR_MUL;
        fetch("mul");
        check_eq("add/count", 64'(InstrCount), 64'd2);
        expect_cycle("mul/T3", B_RYIN, 12'h0, 16'h0, 16'h0008);
        expect_cycle("mul/T4", B_RZIN, X_MUL, 16'h0, 16'h0010);
        expect_cycle("mul/T5", B_ZLO | B_LOIN, 12'h0, 16'h0, 16'h0);
        expect_cycle("mul/T6", B_ZHI | B_HIIN, 12'h0, 16'h0, 16'h0);
        IR = IR_BAD;
        fetch("bad");
        check_eq("mul/count", 64'(InstrCount), 64'd3);
        for (int i = 0; i < 20; i++) begin
            expect_cycle("halt", 16'h0, 12'h0, 16'h0, 16'h0);
            check_eq("halt/illegal", 64'(Illegal), 64'h1);
            check_eq("halt/count", 64'(InstrCount), 64'd3);
        end

        reset = 1'b1;
        #1;
        expect_zero("halt_reset");
        check_eq("halt_reset/count", 64'(InstrCount), 64'd0);
        @(negedge Clock);
        reset = 1'b0;

        IR = IR_AND;
        fetch("abort");
        expect_cycle("abort/T3", B_RYIN, 12'h0, 16'h0, 16'h0004);
        expect_cycle("abort/T4", B_RZIN, X_AND, 16'h0, 16'h0010);
        #2 reset = 1'b1;
        #1;
        expect_zero("abort_reset");
        check_eq("abort_reset/count", 64'(InstrCount), 64'd0);
        @(negedge Clock);
        reset = 1'b0;

        fetch("b2b_and");
        expect_cycle("b2b_and/T3", B_RYIN, 12'h0, 16'h0, 16'h0004);
        expect_cycle("b2b_and/T4", B_RZIN, X_AND, 16'h0, 16'h0010);
        expect_cycle("b2b_and/T5", B_ZLO, 12'h0, 16'h0020, 16'h0);
        IR = IR_NOT;
        fetch("b2b_not");
        expect_cycle("b2b_not/T3", B_RYIN, 12'h0, 16'h0, 16'h0080);
        expect_cycle("b2b_not/T4", B_RZIN, X_NOT, 16'h0, 16'h0080);
        expect_cycle("b2b_not/T5", B_ZLO, 12'h0, 16'h0040, 16'h0);
        IR = IR_DIV;
        fetch("b2b_div");
        check_eq("b2b_not/count", 64'(InstrCount), 64'd2);
        expect_cycle("b2b_div/T3", B_RYIN, 12'h0, 16'h0, 16'h0100);
        expect_cycle("b2b_div/T4", B_RZIN, X_DIV, 16'h0, 16'h0200);
        expect_cycle("b2b_div/T5", B_ZLO | B_LOIN, 12'h0, 16'h0, 16'h0);
        expect_cycle("b2b_div/T6", B_ZHI | B_HIIN, 12'h0, 16'h0, 16'h0);
        expect_cycle("b2b_end/T0", B_PCOUT | B_MARIN | B_INCPC | B_RZIN, 12'h0, 16'h0, 16'h0);
        check_eq("b2b/count", 64'(InstrCount), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
